sc_readback_receiver: RTL and testbench

- Deserializes the MAROC slow-control readback stream (chip serial output, 829-bit frame, LSB first) into a parallel frame register.
- Sits beside the slow-control transmitter in the same 5 MHz domain. Software uses it to read back and check the configuration register after each load.
- Provides frame-complete, abort, timeout and stray-bit status.

---
 rtl/sc_frame_pkg.sv | 32 +++
 rtl/sc_rb_compare.sv | 55 +++++
 rtl/sc_readback_receiver.sv | 141 ++++++++++++++
 tb/tb_sc_readback_receiver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_frame_pkg.sv
// Shared MAROC slow-control frame definitions: frame length, field map and
// readback receiver state encodings. Used by both the transmitter and receiver.
package sc_frame_pkg;

    localparam int unsigned FRAME_LEN      = 829;
    localparam int unsigned RB_CNT_W       = 10;
    localparam int unsigned RB_TIMEOUT     = 1023;

    localparam int unsigned DAC2_LSB       = 3;
    localparam int unsigned DAC2_W         = 10;
    localparam int unsigned DAC1_LSB       = 13;
    localparam int unsigned DAC1_W         = 10;
    localparam int unsigned MASK_OR_LSB    = 27;
    localparam int unsigned MASK_OR_W      = 128;
    localparam int unsigned GLOBAL_CFG_LSB = 155;
    localparam int unsigned GLOBAL_CFG_W   = 34;
    localparam int unsigned GAIN_LSB       = 189;
    localparam int unsigned GAIN_W         = 576;
    localparam int unsigned CTEST_LSB      = 765;
    localparam int unsigned CTEST_W        = 64;

    typedef logic [1:0] sc_rb_state_t;

    localparam sc_rb_state_t ST_IDLE    = 2'd0;
    localparam sc_rb_state_t ST_CAPTURE = 2'd1;
    localparam sc_rb_state_t ST_DONE    = 2'd2;

    function automatic int unsigned field_msb(input int unsigned lsb, input int unsigned width);
        return lsb + width - 1;
    endfunction

endpackage

// File: rtl/sc_rb_compare.sv
// Serial readback checker: counts bits differing from the expected frame
// (saturating) and records the index of the first differing bit.
module sc_rb_compare #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_sample,
    input  logic             i_last,
    input  logic             i_bit,
    input  logic             i_exp_bit,
    input  logic [CNT_W-1:0] i_idx,
    output logic             o_match,
    output logic [CNT_W-1:0] o_mismatch_cnt,
    output logic [CNT_W-1:0] o_first_err_idx
);

    logic             w_diff;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_first;
    logic             r_match;

    assign w_diff = i_bit ^ i_exp_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_match <= 1'b0;
            r_cnt   <= '0;
            r_first <= '1;
        end else if (i_clear) begin
            r_match <= 1'b0;
            r_cnt   <= '0;
            r_first <= '1;
        end else if (i_sample) begin
            if (w_diff) begin
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (r_cnt == '0) begin
                    r_first <= i_idx;
                end
            end
            // Final bit is folded in here so match is ready alongside frame_valid
            if (i_last) begin
                r_match <= (r_cnt == '0) && !w_diff;
            end
        end
    end

    assign o_match         = r_match;
    assign o_mismatch_cnt  = r_cnt;
    assign o_first_err_idx = r_first;

endmodule

// File: rtl/sc_readback_receiver.sv
// Deserializes the MAROC slow-control readback stream (LSB first) into a frame
// register. Define SC_READBACK_COMPARE_EN to add the serial compare-to-expected logic.
module sc_readback_receiver #(
    parameter int unsigned FRAME_LEN = sc_frame_pkg::FRAME_LEN,
    parameter int unsigned CNT_W     = sc_frame_pkg::RB_CNT_W,
    parameter int unsigned TIMEOUT   = sc_frame_pkg::RB_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sd_in,
    input  logic                 sd_valid,
    output logic [FRAME_LEN-1:0] frame,
    output logic                 frame_valid,
    output logic                 busy,
    output logic [CNT_W-1:0]     bit_cnt,
    output logic                 abort,
    output logic                 timeout,
    output logic                 stray
`ifdef SC_READBACK_COMPARE_EN
    ,
    input  logic [FRAME_LEN-1:0] expected,
    output logic                 match,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic [CNT_W-1:0]     first_err_idx
`endif
);

    import sc_frame_pkg::*;

    localparam int unsigned        IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    sc_rb_state_t         r_state;
    logic [FRAME_LEN-1:0] r_sr;
    logic [FRAME_LEN-1:0] r_frame;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [IDLE_W-1:0]    r_idle_cnt;
    logic                 r_abort;
    logic                 r_timeout;
    logic                 r_stray;

    logic                 w_capture;
    logic                 w_accept;
    logic                 w_last;

    assign w_capture = (r_state == ST_CAPTURE);
    assign w_accept  = w_capture && sd_valid && !start;
    assign w_last    = w_accept && (r_bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sr       <= '0;
            r_frame    <= '0;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
            r_abort    <= 1'b0;
            r_timeout  <= 1'b0;
            r_stray    <= 1'b0;
        end else begin
            r_abort   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_CAPTURE;
                        r_sr       <= '0;
                        r_bit_cnt  <= '0;
                        r_idle_cnt <= '0;
                        r_stray    <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        if (sd_valid) begin
                            r_stray <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    // start wins over a same-cycle sd_valid; that bit is dropped
                    if (start) begin
                        r_sr       <= '0;
                        r_bit_cnt  <= '0;
                        r_idle_cnt <= '0;
                        r_abort    <= 1'b1;
                    end else if (w_accept) begin
                        r_sr       <= {sd_in, r_sr[FRAME_LEN-1:1]};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        r_idle_cnt <= '0;
                        if (w_last) begin
                            r_frame <= {sd_in, r_sr[FRAME_LEN-1:1]};
                            r_state <= ST_DONE;
                        end
                    end else if (r_idle_cnt == IDLE_LAST) begin
                        r_timeout  <= 1'b1;
                        r_idle_cnt <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign frame       = r_frame;
    assign frame_valid = (r_state == ST_DONE);
    assign busy        = w_capture;
    assign bit_cnt     = r_bit_cnt;
    assign abort       = r_abort;
    assign timeout     = r_timeout;
    assign stray       = r_stray;

`ifdef SC_READBACK_COMPARE_EN
    logic w_exp_bit;

    // expected is held stable during capture, so it can be indexed serially
    assign w_exp_bit = expected[r_bit_cnt];

    sc_rb_compare #(
        .CNT_W (CNT_W)
    ) u_compare (
        .clk             (clk),
        .rst             (rst),
        .i_clear         (start),
        .i_sample        (w_accept),
        .i_last          (w_last),
        .i_bit           (sd_in),
        .i_exp_bit       (w_exp_bit),
        .i_idx           (r_bit_cnt),
        .o_match         (match),
        .o_mismatch_cnt  (mismatch_cnt),
        .o_first_err_idx (first_err_idx)
    );
`endif

endmodule

// File: tb/tb_sc_readback_receiver.sv
// Self-checking bench for sc_readback_receiver: per-cycle vector table plus
// hand-written full-frame, abort, timeout, stray and reset sequences.
module tb_sc_readback_receiver;

    localparam int unsigned FL = 829;
    localparam int unsigned CW = 10;
    localparam int unsigned TO = 1023;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sd_in;
    logic          sd_valid;
    logic [FL-1:0] frame;
    logic          frame_valid;
    logic          busy;
    logic [CW-1:0] bit_cnt;
    logic          abort;
    logic          timeout;
    logic          stray;
`ifdef SC_READBACK_COMPARE_EN
    logic [FL-1:0] expected;
    logic          match;
    logic [CW-1:0] mismatch_cnt;
    logic [CW-1:0] first_err_idx;
`endif

    int n_pass  = 0;
    int n_total = 0;

    sc_readback_receiver #(
        .FRAME_LEN (FL),
        .CNT_W     (CW),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sd_in         (sd_in),
        .sd_valid      (sd_valid),
        .frame         (frame),
        .frame_valid   (frame_valid),
        .busy          (busy),
        .bit_cnt       (bit_cnt),
        .abort         (abort),
        .timeout       (timeout),
        .stray         (stray)
`ifdef SC_READBACK_COMPARE_EN
        ,
        .expected      (expected),
        .match         (match),
        .mismatch_cnt  (mismatch_cnt),
        .first_err_idx (first_err_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          s;
        logic          v;
        logic          d;
        logic          e_busy;
        logic          e_abort;
        logic          e_stray;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_frame(input string name, input logic [FL-1:0] act, input logic [FL-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive inputs, take one rising edge, then settle for sampling
    task automatic tick(input logic s, input logic v, input logic d);
        start    = s;
        sd_valid = v;
        sd_in    = d;
        @(posedge clk);
        #1;
        start    = 1'b0;
        sd_valid = 1'b0;
        sd_in    = 1'b0;
    endtask

    initial begin
        logic [FL-1:0] exp_alt;
        logic [FL-1:0] exp_ones;
        int            fv_early;
        int            n_abort;
        int            n_to_early;

        for (int i = 0; i < int'(FL); i++) begin
            exp_alt[i] = i[0];
        end
        exp_ones = '1;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd1};

`ifdef SC_READBACK_COMPARE_EN
        expected = '0;
`endif
        start = 1'b0; sd_valid = 1'b0; sd_in = 1'b0;
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_cnt",   {22'd0, bit_cnt}, 32'd0);
        chk("rst_fv",    {31'd0, frame_valid}, 32'd0);
        chk("rst_stray", {31'd0, stray}, 32'd0);
        chk_frame("rst_frame", frame, '0);
`ifdef SC_READBACK_COMPARE_EN
        chk("rst_first", {22'd0, first_err_idx}, 32'h3FF);
        chk("rst_mcnt",  {22'd0, mismatch_cnt}, 32'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].s, tbl[i].v, tbl[i].d);
            chk($sformatf("vec%0d_busy", i),  {31'd0, busy},  {31'd0, tbl[i].e_busy});
            chk($sformatf("vec%0d_abort", i), {31'd0, abort}, {31'd0, tbl[i].e_abort});
            chk($sformatf("vec%0d_stray", i), {31'd0, stray}, {31'd0, tbl[i].e_stray});
            chk($sformatf("vec%0d_cnt", i),   {22'd0, bit_cnt}, {22'd0, tbl[i].e_cnt});
        end

        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Full frame, alternating pattern
        tick(1'b1, 1'b0, 1'b0);
        chk("t1_busy_start", {31'd0, busy}, 32'd1);
        fv_early = 0;
        for (int i = 0; i < int'(FL); i++) begin
            tick(1'b0, 1'b1, i[0]);
            if (i < int'(FL) - 1 && frame_valid) fv_early++;
        end
        chk("t1_fv_early", fv_early, 32'd0);
        chk("t1_fv",       {31'd0, frame_valid}, 32'd1);
        chk("t1_busy_done", {31'd0, busy}, 32'd0);
        chk("t1_cnt",      {22'd0, bit_cnt}, 32'd829);
        chk_frame("t1_frame", frame, exp_alt);
        tick(1'b0, 1'b0, 1'b0);
        chk("t1_fv_after",  {31'd0, frame_valid}, 32'd0);
        chk("t1_cnt_hold",  {22'd0, bit_cnt}, 32'd829);

        // Abort mid-capture then full frame of ones
        tick(1'b1, 1'b0, 1'b0);
        n_abort = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (abort) n_abort++;
        end
        tick(1'b1, 1'b0, 1'b0);
        chk("t2_abort_pulse", {31'd0, abort}, 32'd1);
        chk("t2_cnt_restart", {22'd0, bit_cnt}, 32'd0);
        chk_frame("t2_frame_kept", frame, exp_alt);
        if (abort) n_abort++;
        fv_early = 0;
        for (int i = 0; i < int'(FL); i++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (abort) n_abort++;
            if (i < int'(FL) - 1 && frame_valid) fv_early++;
        end
        chk("t2_abort_count", n_abort, 32'd1);
        chk("t2_fv_early", fv_early, 32'd0);
        chk("t2_fv", {31'd0, frame_valid}, 32'd1);
        chk_frame("t2_frame", frame, exp_ones);

        // Timeout after 100 bits
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b1, 1'b0);
        end
        n_to_early = 0;
        for (int k = 1; k <= int'(TO); k++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (k < int'(TO) && (timeout || !busy)) n_to_early++;
        end
        chk("t3_early", n_to_early, 32'd0);
        chk("t3_timeout", {31'd0, timeout}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_fv", {31'd0, frame_valid}, 32'd0);
        chk_frame("t3_frame_kept", frame, exp_ones);
        tick(1'b0, 1'b0, 1'b0);
        chk("t3_timeout_once", {31'd0, timeout}, 32'd0);

        // Stray in IDLE, cleared by start; then reset mid-capture
        chk("t4_stray_pre", {31'd0, stray}, 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
        chk("t4_stray_set", {31'd0, stray}, 32'd1);
        tick(1'b1, 1'b0, 1'b0);
        chk("t4_stray_clr", {31'd0, stray}, 32'd0);
        for (int i = 0; i < 500; i++) tick(1'b0, 1'b1, 1'b1);
        chk("t4_cnt500", {22'd0, bit_cnt}, 32'd500);
        rst = 1'b1;
        tick(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        chk_frame("t4_rst_frame", frame, '0);
        chk("t4_rst_busy", {31'd0, busy}, 32'd0);
        chk("t4_rst_cnt", {22'd0, bit_cnt}, 32'd0);
        chk("t4_rst_flags", {28'd0, frame_valid, abort, timeout, stray}, 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        chk("t4_rst_fv", {31'd0, frame_valid}, 32'd0);

`ifdef SC_READBACK_COMPARE_EN
        expected = '0;
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < int'(FL); i++) begin
            tick(1'b0, 1'b1, (i == 13 || i == 700));
        end
        chk("c1_fv",    {31'd0, frame_valid}, 32'd1);
        chk("c1_match", {31'd0, match}, 32'd0);
        chk("c1_mcnt",  {22'd0, mismatch_cnt}, 32'd2);
        chk("c1_first", {22'd0, first_err_idx}, 32'd13);

        for (int i = 0; i < int'(FL); i++) expected[i] = 1'($urandom_range(0, 1));
        tick(1'b1, 1'b0, 1'b0);
        chk("c2_first_clr", {22'd0, first_err_idx}, 32'h3FF);
        chk("c2_mcnt_clr",  {22'd0, mismatch_cnt}, 32'd0);
        for (int i = 0; i < int'(FL); i++) begin
            tick(1'b0, 1'b1, expected[i]);
        end
        chk("c2_fv",    {31'd0, frame_valid}, 32'd1);
        chk("c2_match", {31'd0, match}, 32'd1);
        chk("c2_mcnt",  {22'd0, mismatch_cnt}, 32'd0);
        chk("c2_first", {22'd0, first_err_idx}, 32'h3FF);
        chk_frame("c2_frame", frame, expected);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
